// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch/decode/execute control FSM with retired-instruction counter; SINGLE_STEP_EN adds a step input and PAUSE state
module cpu_control_unit #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             LD,
  input  logic             ADD,
  input  logic             SUB,
  input  logic             AND,
  input  logic             OR,
  input  logic             HALT,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             IIR,
  output logic             mar_pc,
  output logic             mar_ir,
  output logic             mem_rd,
  output logic             pc_inc,
  output logic             acc_ld,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             halted,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
);
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH0 = 4'd1,
    FETCH1 = 4'd2,
    DECODE = 4'd3,
    LD0    = 4'd4,
    LD1    = 4'd5,
    ALU    = 4'd6,
    HALTED = 4'd7
`ifdef SINGLE_STEP_EN
    , PAUSE = 4'd8
`endif
  } state_t;

`ifdef SINGLE_STEP_EN
  localparam state_t RESUME = PAUSE;
`else
  localparam state_t RESUME = FETCH0;
`endif

  state_t     state, nxt;
  logic [3:0] wcnt;
  logic [2:0] op, op_d;
  logic       last, retire, any_alu;

  assign last    = wcnt == 4'(MEM_WAIT);
  assign any_alu = ADD | SUB | AND | OR;
  assign op_d    = ADD ? 3'd1 : SUB ? 3'd2 : AND ? 3'd3 : OR ? 3'd4 : 3'd0;

  // next-state selection and retire detection
  always_comb begin
    nxt    = state;
    retire = 1'b0;
    case (state)
      IDLE:   nxt = start ? FETCH0 : IDLE;
      FETCH0: nxt = FETCH1;
      FETCH1: nxt = last ? DECODE : FETCH1;
      DECODE: begin
        nxt    = HALT ? HALTED : LD ? LD0 : any_alu ? ALU : RESUME;
        retire = HALT | !(LD | any_alu);
      end
      LD0:    nxt = LD1;
      LD1: begin
        nxt    = last ? RESUME : LD1;
        retire = last;
      end
      ALU: begin
        nxt    = RESUME;
        retire = 1'b1;
      end
`ifdef SINGLE_STEP_EN
      PAUSE:  nxt = step ? FETCH0 : PAUSE;
`endif
      default: nxt = state;
    endcase
  end

  // state, memory wait counter, captured ALU op and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      op        <= 3'd0;
      instr_cnt <= '0;
    end else begin
      state <= nxt;
      wcnt  <= ((state == FETCH1 || state == LD1) && !last) ? wcnt + 4'd1 : 4'd0;
      if (state == DECODE) op <= op_d;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign mar_pc  = state == FETCH0;
  assign mar_ir  = state == LD0;
  assign mem_rd  = state == FETCH1 || state == LD1;
  assign IIR     = state == FETCH1 && last;
  assign pc_inc  = state == FETCH1 && last;
  assign acc_ld  = (state == LD1 && last) || state == ALU;
  assign alu_op  = (state == LD1 && last) ? 3'd5 : state == ALU ? op : 3'd0;
  assign halted  = state == HALTED;
  assign state_o = state;
`ifdef SINGLE_STEP_EN
  assign busy    = !(state == IDLE || state == HALTED || state == PAUSE);
`else
  assign busy    = !(state == IDLE || state == HALTED);
`endif
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: two instances (MEM_WAIT=0/CNT_W=4 and MEM_WAIT=2/CNT_W=16) checked against a per-cycle schedule model
module tb_cpu_control_unit;
  typedef logic [15:0] vec_t;

  logic clk = 1'b0;
  logic rst_n, start, LD, ADD, SUB, AND, OR, HALT;
  wire [14:0] o0, o1;
  wire [3:0]  c0;
  wire [15:0] c1;
  int vectors = 0;
  int miscompares = 0;

  vec_t        sch [2][32];
  int          len [2];
  int          pos [2];
  vec_t        cur [2];
  int unsigned cnt [2];
  int          mw  [2];

  always #5 clk = ~clk;

  cpu_control_unit #(.MEM_WAIT(0), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .LD(LD), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .HALT(HALT),
    .IIR(o0[10]), .mar_pc(o0[9]), .mar_ir(o0[8]), .mem_rd(o0[7]), .pc_inc(o0[6]),
    .acc_ld(o0[5]), .alu_op(o0[4:2]), .busy(o0[1]), .halted(o0[0]),
    .state_o(o0[14:11]), .instr_cnt(c0)
  );

  cpu_control_unit #(.MEM_WAIT(2), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .LD(LD), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .HALT(HALT),
    .IIR(o1[10]), .mar_pc(o1[9]), .mar_ir(o1[8]), .mem_rd(o1[7]), .pc_inc(o1[6]),
    .acc_ld(o1[5]), .alu_op(o1[4:2]), .busy(o1[1]), .halted(o1[0]),
    .state_o(o1[14:11]), .instr_cnt(c1)
  );

  // expected output word for one cycle; ret marks a cycle whose ending edge retires
  function automatic vec_t mk(input int st, input bit iir, input bit mpc, input bit mir,
                              input bit mrd, input bit pci, input bit acl, input int op, input bit ret);
    return {ret, st[3:0], iir, mpc, mir, mrd, pci, acl, op[2:0], st != 0 && st != 7, st == 7};
  endfunction

  task automatic add(input int i, input vec_t v);
    sch[i][len[i]] = v;
    len[i]++;
  endtask

  task automatic add_fetch(input int i);
    len[i] = 0;
    pos[i] = 0;
    add(i, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < mw[i]; k++) add(i, mk(2, 0, 0, 0, 1, 0, 0, 0, 0));
    add(i, mk(2, 1, 0, 0, 1, 1, 0, 0, 0));
    add(i, mk(3, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // advance the model across one rising edge using the inputs present before it
  task automatic step_model(input int i);
    vec_t c;
    int st;
    c  = cur[i];
    st = int'(c[14:11]);
    if (!rst_n) begin
      cur[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cnt[i] = 0;
      len[i] = 0;
      pos[i] = 0;
    end else begin
      if (c[15]) cnt[i]++;
      if (st == 0 && start) add_fetch(i);
      else if (st == 3) begin
        len[i] = 0;
        pos[i] = 0;
        if (HALT) begin
          cnt[i]++;
          add(i, mk(7, 0, 0, 0, 0, 0, 0, 0, 0));
        end else if (LD) begin
          add(i, mk(4, 0, 0, 1, 0, 0, 0, 0, 0));
          for (int k = 0; k < mw[i]; k++) add(i, mk(5, 0, 0, 0, 1, 0, 0, 0, 0));
          add(i, mk(5, 0, 0, 0, 1, 0, 1, 5, 1));
        end else if (ADD | SUB | AND | OR)
          add(i, mk(6, 0, 0, 0, 0, 0, 1, ADD ? 1 : SUB ? 2 : AND ? 3 : 4, 1));
        else begin
          cnt[i]++;
          add_fetch(i);
        end
      end else if (st != 0 && st != 7 && pos[i] >= len[i]) add_fetch(i);
      if (pos[i] < len[i]) begin
        cur[i] = sch[i][pos[i]];
        pos[i]++;
      end
    end
  endtask

  task automatic check(input int i, input logic [14:0] o, input logic [15:0] cv, input int cw);
    logic [15:0] ec;
    ec = 16'(cnt[i] % (32'd1 << cw));
    vectors++;
    assert (o === cur[i][14:0]) else begin
      miscompares++;
      $error("FAIL outs%0d t=%0t observed=%h expected=%h", i, $time, o, cur[i][14:0]);
    end
    vectors++;
    assert (cv === ec) else begin
      miscompares++;
      $error("FAIL instr_cnt%0d t=%0t observed=%0d expected=%0d", i, $time, cv, ec);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input logic [5:0] mask);
    rst_n = r;
    start = s;
    {HALT, LD, ADD, SUB, AND, OR} = 6'($urandom) & mask;
    @(posedge clk);
    step_model(0);
    step_model(1);
    #1;
    check(0, o0, {12'd0, c0}, 4);
    check(1, o1, c1, 16);
  endtask

  initial begin
    mw[0] = 0;
    mw[1] = 2;
    for (int i = 0; i < 2; i++) begin
      cur[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cnt[i] = 0;
      len[i] = 0;
      pos[i] = 0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    {HALT, LD, ADD, SUB, AND, OR} = 6'd0;
    repeat (2) cyc(0, 0, 6'd0);
    cyc(1, 1, 6'b001111);
    repeat (60) cyc(1, 1'($urandom), 6'b001111);
    repeat (100) cyc(1, 1'($urandom), 6'b011111);
    repeat (40) cyc(1, 1'($urandom), 6'd0);
    repeat (60) cyc(1, 1'($urandom), 6'b111111);
    repeat (20) cyc(1, 1, 6'b111111);
    cyc(0, 0, 6'd0);
    cyc(1, 1, 6'd0);
    repeat (2) cyc(1, 0, 6'd0);
    cyc(0, 0, 6'd0);
    repeat (3) cyc(1, 0, 6'd0);
    repeat (150) cyc(($urandom % 20) != 0, 1'($urandom), 6'b011111);
    repeat (40) cyc(1, 1'($urandom), 6'b111111);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
